// File: rtl/aes128_key_sched.sv
// Iterative AES-128 key expansion: emits round keys rk0..rk10 one per handshake,
// computing each next key on the fly from the previous one with four S-boxes.
module aes128_key_sched #(
    parameter bit REPEAT_EN = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         rk_last,
    output logic         busy
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [127:0]  key_reg;
    logic [127:0]  w;
    logic [3:0]    idx;
    logic [7:0]    rcon;
    logic          handshake;
    logic [31:0]   rot;
    logic [31:0]   t;
    logic [31:0]   w0_next;
    logic [31:0]   w1_next;
    logic [31:0]   w2_next;
    logic [31:0]   w3_next;

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed algebraically: inverse is x^254 in GF(2^8), then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (key_valid) state_next = RUN;
            RUN:     if (handshake && idx == 4'd10 && !REPEAT_EN) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        key_ready = (state == IDLE);
        rk_valid  = (state == RUN);
        busy      = (state != IDLE);
        rk_out    = w;
        rk_idx    = idx;
        rk_last   = (state == RUN) && (idx == 4'd10);
    end

    assign handshake = rk_valid && rk_ready;

    // One round of the FIPS-197 word recurrence, four words at once.
    assign rot     = {w[23:0], w[31:24]};
    assign t       = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
                     ^ {rcon, 24'h000000};
    assign w0_next = w[127:96] ^ t;
    assign w1_next = w[95:64]  ^ w0_next;
    assign w2_next = w[63:32]  ^ w1_next;
    assign w3_next = w[31:0]   ^ w2_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_reg <= '0;
            w       <= '0;
            idx     <= '0;
            rcon    <= 8'h01;
        end else if (state == IDLE) begin
            if (key_valid) begin
                key_reg <= key_in;
                w       <= key_in;
                idx     <= '0;
                rcon    <= 8'h01;
            end
        end else if (handshake) begin
            if (idx != 4'd10) begin
                w    <= {w0_next, w1_next, w2_next, w3_next};
                rcon <= xtime(rcon);
                idx  <= idx + 4'd1;
            end else if (REPEAT_EN) begin
                w    <= key_reg;
                idx  <= '0;
                rcon <= 8'h01;
            end
        end
    end

endmodule
